// File: rtl/vec_stream_bridge_if.sv
// Host/layer-side signal bundle for vec_stream_bridge: start, send, receive and done handshakes.
// The bridge connects through the slave modport; the driving side uses master.
interface vec_stream_bridge_if #(
   parameter int M = 8,
   parameter int N = 8,
   parameter int T = 12
) ();
   logic           start_valid;
   logic           start_ready;
   logic [N*T-1:0] x_vec;
   logic           m_valid;
   logic           m_ready;
   logic [T-1:0]   data_out;
   logic           s_valid;
   logic           s_ready;
   logic [T-1:0]   data_in;
   logic [M*T-1:0] y_vec;
   logic           done_valid;
   logic           done_ready;
   logic           err;

   modport master (
      output start_valid, x_vec, m_ready, s_valid, data_in, done_ready,
      input  start_ready, m_valid, data_out, s_ready, y_vec, done_valid, err
   );

   modport slave (
      input  start_valid, x_vec, m_ready, s_valid, data_in, done_ready,
      output start_ready, m_valid, data_out, s_ready, y_vec, done_valid, err
   );
endinterface

// File: rtl/vec_stream_bridge.sv
// Captures an N-word vector, streams it word by word to a layer, collects M result words.
// Optional macro VEC_STREAM_BRIDGE_RELU_CHECK_EN adds a sticky negative-result flag on err.
module vec_stream_bridge #(
   parameter int M = 8,
   parameter int N = 8,
   parameter int T = 12
) (
   input  logic               clk,
   input  logic               reset,
   vec_stream_bridge_if.slave bus
);
   localparam int CWN = $clog2(N + 1);
   localparam int CWM = $clog2(M + 1);
   localparam logic [CWN-1:0] LAST_SEND = CWN'(N - 1);
   localparam logic [CWM-1:0] LAST_RECV = CWM'(M - 1);

   typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

   state_t         state;
   logic [N*T-1:0] x_reg;
   logic [CWN-1:0] send_cnt;
   logic [CWM-1:0] recv_cnt;
   logic           m_valid_r;
   logic           s_ready_r;
   logic           done_valid_r;
   logic [T-1:0]   data_out_r;
   logic [M*T-1:0] y_reg;

   function automatic logic [T-1:0] word_at(input logic [N*T-1:0] v, input logic [CWN-1:0] idx);
      logic [T-1:0] w;
      w = '0;
      for (int i = 0; i < N; i++)
         if (int'(idx) == i) w = v[i*T +: T];
      return w;
   endfunction

   // data_out is preloaded with the next word so it is valid in the same cycle as m_valid
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         send_cnt     <= '0;
         recv_cnt     <= '0;
         m_valid_r    <= 1'b0;
         s_ready_r    <= 1'b0;
         done_valid_r <= 1'b0;
         data_out_r   <= '0;
         y_reg        <= '0;
      end else begin
         unique case (state)
            IDLE: if (bus.start_valid) begin
               x_reg      <= bus.x_vec;
               data_out_r <= bus.x_vec[T-1:0];
               send_cnt   <= '0;
               recv_cnt   <= '0;
               m_valid_r  <= 1'b1;
               state      <= SEND;
            end
            SEND: if (bus.m_ready) begin
               send_cnt <= send_cnt + 1'b1;
               if (send_cnt == LAST_SEND) begin
                  m_valid_r <= 1'b0;
                  s_ready_r <= 1'b1;
                  state     <= RECV;
               end else begin
                  data_out_r <= word_at(x_reg, send_cnt + 1'b1);
               end
            end
            RECV: if (bus.s_valid) begin
               for (int j = 0; j < M; j++)
                  if (int'(recv_cnt) == j) y_reg[j*T +: T] <= bus.data_in;
               recv_cnt <= recv_cnt + 1'b1;
               if (recv_cnt == LAST_RECV) begin
                  s_ready_r    <= 1'b0;
                  done_valid_r <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: if (bus.done_ready) begin
               done_valid_r <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef VEC_STREAM_BRIDGE_RELU_CHECK_EN
   // A negative result cannot come out of a ReLU layer; remember it until reset
   logic err_r;
   always_ff @(posedge clk) begin
      if (reset) err_r <= 1'b0;
      else if (state == RECV && bus.s_valid && bus.data_in[T-1]) err_r <= 1'b1;
   end
   assign bus.err = err_r;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.start_ready = (state == IDLE) && !reset;
   assign bus.m_valid     = m_valid_r;
   assign bus.data_out    = data_out_r;
   assign bus.s_ready     = s_ready_r;
   assign bus.done_valid  = done_valid_r;
   assign bus.y_vec       = y_reg;
endmodule

// File: tb/tb_vec_stream_bridge.sv
// Bench for vec_stream_bridge: directed transactions plus randomized traffic against a
// count-based transaction model.
module tb_vec_stream_bridge;
   localparam int M = 8;
   localparam int N = 8;
   localparam int T = 12;

   logic clk;
   logic rst;
   vec_stream_bridge_if #(.M(M), .N(N), .T(T)) bus ();

   vec_stream_bridge #(.M(M), .N(N), .T(T)) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: progress is tracked only as words sent/received per transaction
   bit             model_ok = 0;
   bit             active   = 0;
   int             sent     = 0;
   int             recvd    = 0;
   int             ndone    = 0;
   bit             err_m    = 0;
   logic [N*T-1:0] xm       = '0;
   logic [M*T-1:0] ym       = '0;

   always @(posedge clk) begin
      if (rst) begin
         model_ok = 1; active = 0; sent = 0; recvd = 0; ym = '0; err_m = 0;
      end else if (model_ok) begin
         if (!active) begin
            if (bus.start_valid) begin
               active = 1; xm = bus.x_vec; sent = 0; recvd = 0;
            end
         end else if (sent < N) begin
            if (bus.m_ready) sent++;
         end else if (recvd < M) begin
            if (bus.s_valid) begin
               ym[recvd*T +: T] = bus.data_in;
`ifdef VEC_STREAM_BRIDGE_RELU_CHECK_EN
               if (bus.data_in[T-1]) err_m = 1;
`endif
               recvd++;
            end
         end else if (bus.done_ready) begin
            active = 0;
            ndone++;
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("start_ready", bus.start_ready, !active && !rst);
         chk("m_valid", bus.m_valid, active && sent < N);
         if (active && sent < N) chk("data_out", bus.data_out, xm[sent*T +: T]);
         chk("s_ready", bus.s_ready, active && sent == N && recvd < M);
         chk("done_valid", bus.done_valid, active && recvd == M);
         chk("y_vec", bus.y_vec, ym);
         chk("err", bus.err, err_m);
      end
   end

   bit din_auto = 0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (din_auto) bus.data_in = T'(10 + recvd);
      end
   end

   task automatic rand_x();
      for (int i = 0; i < N; i++) bus.x_vec[i*T +: T] = T'($urandom);
   endtask

   logic [M*T-1:0] y_lit;

   initial begin
      rst = 1'b1;
      bus.start_valid = 0; bus.x_vec = '0; bus.m_ready = 0;
      bus.s_valid = 0; bus.data_in = '0; bus.done_ready = 0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_start_ready", bus.start_ready, 1'b0);
      chk("rst_m_valid", bus.m_valid, 1'b0);
      chk("rst_s_ready", bus.s_ready, 1'b0);
      chk("rst_done_valid", bus.done_valid, 1'b0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_y_vec", bus.y_vec, 0);
      chk("rst_err", bus.err, 1'b0);
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      chk("idle_start_ready", bus.start_ready, 1'b1);

      // Words 1..8 out, results 10..17 back, full throughput
      @(posedge clk); #2;
      for (int i = 0; i < N; i++) bus.x_vec[i*T +: T] = T'(i + 1);
      bus.start_valid = 1; bus.m_ready = 1; bus.s_valid = 1; din_auto = 1;
      @(posedge clk); #2;
      bus.start_valid = 0;
      rand_x();
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         chk("dir_m_valid", bus.m_valid, 1'b1);
         chk("dir_data_out", bus.data_out, i + 1);
      end
      for (int j = 0; j < M; j++) begin
         @(negedge clk);
         chk("dir_s_ready", bus.s_ready, 1'b1);
         chk("dir_no_done", bus.done_valid, 1'b0);
      end
      @(negedge clk);
      for (int j = 0; j < M; j++) y_lit[j*T +: T] = T'(10 + j);
      chk("dir_done", bus.done_valid, 1'b1);
      chk("dir_s_ready_off", bus.s_ready, 1'b0);
      chk("dir_y_vec", bus.y_vec, y_lit);
      chk("dir_y_word0", bus.y_vec[T-1:0], 12'd10);
      chk("dir_y_word7", bus.y_vec[7*T +: T], 12'd17);
      chk("dir_err", bus.err, 1'b0);
      @(posedge clk); #2 bus.start_valid = 1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("hold_done", bus.done_valid, 1'b1);
      chk("hold_y_vec", bus.y_vec, y_lit);
      @(posedge clk); #2 bus.done_ready = 1; bus.start_valid = 0;
      @(posedge clk); #2 bus.done_ready = 0; din_auto = 0;
      @(negedge clk);
      chk("back_idle", bus.start_ready, 1'b1);

      // Reset after three words sent aborts the transaction
      @(posedge clk); #2;
      rand_x();
      bus.start_valid = 1; bus.m_ready = 1;
      @(posedge clk); #2 bus.start_valid = 0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      chk("abort_m_valid", bus.m_valid, 1'b0);
      chk("abort_done_valid", bus.done_valid, 1'b0);
      chk("abort_start_ready", bus.start_ready, 1'b1);
      chk("abort_y_vec", bus.y_vec, 0);

      // Randomized traffic with stalls, stray handshakes and occasional reset
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         rst             = ($urandom_range(0, 249) == 0);
         bus.start_valid = $urandom_range(0, 1);
         rand_x();
         bus.m_ready     = $urandom_range(0, 1);
         bus.s_valid     = $urandom_range(0, 1);
         bus.data_in     = ($urandom_range(0, 7) == 0) ? 12'h7FF : T'($urandom);
         bus.done_ready  = ($urandom_range(0, 3) == 0);
      end
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      chk("txn_count_ok", ndone >= 10, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
